// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU pixel-writer front end and the scan-out stage.
package gpu_pkg;

   localparam int WIDTH_DEF  = 640;
   localparam int HEIGHT_DEF = 480;

   localparam logic [7:0] REG_X_LO   = 8'd0;
   localparam logic [7:0] REG_X_HI   = 8'd1;
   localparam logic [7:0] REG_Y_LO   = 8'd2;
   localparam logic [7:0] REG_Y_HI   = 8'd3;
   localparam logic [7:0] REG_COLOR  = 8'd4;
   localparam logic [7:0] REG_CMD    = 8'd5;
   localparam logic [7:0] REG_STATUS = 8'd6;

   localparam int CMD_PLOT = 0;
   localparam int CMD_STEP = 1;

   localparam int ST_FULL     = 0;
   localparam int ST_EMPTY    = 1;
   localparam int ST_CNT_LSB  = 2;
   localparam int ST_OVERFLOW = 6;
   localparam int ST_CLIP     = 7;

   localparam logic [7:0] BLACK = 8'h00;
   localparam logic [7:0] WHITE = 8'hFF;

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic [7:0] color;
   } pix_cmd_t;

   function automatic logic in_frame(input logic [9:0] x, input logic [8:0] y,
                                     input int w, input int h);
      return (int'(x) < w) && (int'(y) < h);
   endfunction

endpackage

// File: rtl/gpu_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is dropped even when a pop
// happens on the same edge.
module gpu_fifo #(
   parameter int DEPTH = 8,
   parameter int DW    = 27
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DW-1:0]            din,
   input  logic                     pop,
   output logic [DW-1:0]            dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
   localparam logic [AW:0] ONE_L   = {{AW{1'b0}}, 1'b1};

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign count     = wr_ptr_r - rd_ptr_r;
   assign full      = (count == DEPTH_L);
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign dout      = mem_r[rd_ptr_r[AW-1:0]];

   // Read/write pointers; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + ONE_L;
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + ONE_L;
      end
   end

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
   end

endmodule

// File: rtl/gpu_pixel_writer.sv
// CPU register front end: decodes bus writes into clipped pixel-plot commands and
// queues them for the frame-buffer write port.
module gpu_pixel_writer
   import gpu_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] address_bus,
   inout  wire  [7:0] data_bus,
   input  logic       w,
   input  logic       r,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic [9:0] pix_x,
   output logic [8:0] pix_y,
   output logic [7:0] pix_color
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic          w_prev_r;
   logic          r_prev_r;
   logic [7:0]    addr_prev_r;
   logic [9:0]    x_r;
   logic [8:0]    y_r;
   logic [7:0]    color_r;
   logic          overflow_r;
   logic          clip_r;

   logic          wr_edge_s;
   logic          plot_s;
   logic          step_s;
   logic          in_frame_s;
   logic          push_s;
   logic          ovf_set_s;
   logic          clip_set_s;
   logic          flag_clr_s;
   logic [9:0]    x_step_s;
   logic [8:0]    y_step_s;
   logic          full_s;
   logic          empty_s;
   logic [CW-1:0] count_s;
   logic [3:0]    cnt_sat_s;
   logic [7:0]    status_s;
   logic [7:0]    rd_data_s;
   logic          rd_en_s;
   pix_cmd_t      push_data_s;
   pix_cmd_t      head_s;

   // Command decode, clip test and flag set/clear conditions.
   always_comb begin
      wr_edge_s  = w && !w_prev_r;
      plot_s     = wr_edge_s && (address_bus == REG_CMD) && data_bus[CMD_PLOT];
      step_s     = wr_edge_s && (address_bus == REG_CMD) && data_bus[CMD_STEP];
      in_frame_s = in_frame(x_r, y_r, WIDTH, HEIGHT);
      push_s     = plot_s && in_frame_s;
      ovf_set_s  = push_s && full_s;
      clip_set_s = plot_s && !in_frame_s;
      flag_clr_s = r_prev_r && !r && (addr_prev_r == REG_STATUS);
      push_data_s.x     = x_r;
      push_data_s.y     = y_r;
      push_data_s.color = color_r;
   end

   // Raster-order cursor step with wrap at the frame edges.
   always_comb begin
      if (int'(x_r) + 32'sd1 >= WIDTH) begin
         x_step_s = 10'd0;
         if (int'(y_r) + 32'sd1 >= HEIGHT) begin
            y_step_s = 9'd0;
         end else begin
            y_step_s = y_r + 9'd1;
         end
      end else begin
         x_step_s = x_r + 10'd1;
         y_step_s = y_r;
      end
   end

   // Register file, strobe history and sticky flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_prev_r    <= 1'b0;
         r_prev_r    <= 1'b0;
         addr_prev_r <= 8'd0;
         x_r         <= 10'd0;
         y_r         <= 9'd0;
         color_r     <= 8'd0;
         overflow_r  <= 1'b0;
         clip_r      <= 1'b0;
      end else begin
         w_prev_r    <= w;
         r_prev_r    <= r;
         addr_prev_r <= address_bus;
         if (wr_edge_s) begin
            case (address_bus)
               REG_X_LO:  x_r[7:0] <= data_bus;
               REG_X_HI:  x_r[9:8] <= data_bus[1:0];
               REG_Y_LO:  y_r[7:0] <= data_bus;
               REG_Y_HI:  y_r[8]   <= data_bus[0];
               REG_COLOR: color_r  <= data_bus;
               default: begin
                  if (step_s) begin
                     x_r <= x_step_s;
                     y_r <= y_step_s;
                  end
               end
            endcase
         end
         if (ovf_set_s)       overflow_r <= 1'b1;
         else if (flag_clr_s) overflow_r <= 1'b0;
         if (clip_set_s)      clip_r <= 1'b1;
         else if (flag_clr_s) clip_r <= 1'b0;
      end
   end

   gpu_fifo #(.DEPTH(DEPTH), .DW($bits(pix_cmd_t))) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .din   (push_data_s),
      .pop   (pix_valid && pix_ready),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s),
      .count (count_s)
   );

   // Status word and combinational read-back mux.
   always_comb begin
      if (int'(count_s) > 32'sd15) begin
         cnt_sat_s = 4'd15;
      end else begin
         cnt_sat_s = 4'(count_s);
      end
      status_s                     = 8'd0;
      status_s[ST_FULL]            = full_s;
      status_s[ST_EMPTY]           = empty_s;
      status_s[ST_CNT_LSB +: 4]    = cnt_sat_s;
      status_s[ST_OVERFLOW]        = overflow_r;
      status_s[ST_CLIP]            = clip_r;
      rd_en_s = r && (address_bus <= REG_STATUS);
      case (address_bus)
         REG_X_LO:   rd_data_s = x_r[7:0];
         REG_X_HI:   rd_data_s = {6'd0, x_r[9:8]};
         REG_Y_LO:   rd_data_s = y_r[7:0];
         REG_Y_HI:   rd_data_s = {7'd0, y_r[8]};
         REG_COLOR:  rd_data_s = color_r;
         REG_STATUS: rd_data_s = status_s;
         default:    rd_data_s = 8'd0;
      endcase
   end

   assign data_bus  = rd_en_s ? rd_data_s : 8'hzz;
   assign pix_valid = !empty_s;
   assign pix_x     = pix_valid ? head_s.x     : 10'd0;
   assign pix_y     = pix_valid ? head_s.y     : 9'd0;
   assign pix_color = pix_valid ? head_s.color : 8'd0;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Bench for gpu_pixel_writer: queue-based reference model with per-cycle output
// comparison plus directed register scenarios with literal expectations.
module tb_gpu_pixel_writer;
   import gpu_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] address_bus = 8'd0;
   logic [7:0] tb_data = 8'd0;
   logic       tb_drive = 1'b0;
   logic       w = 1'b0;
   logic       r = 1'b0;
   logic       pix_ready = 1'b0;
   wire  [7:0] data_bus;
   logic       pix_valid;
   logic [9:0] pix_x;
   logic [8:0] pix_y;
   logic [7:0] pix_color;

   assign data_bus = tb_drive ? tb_data : 8'hzz;

   gpu_pixel_writer dut (
      .clk         (clk),
      .reset       (reset),
      .address_bus (address_bus),
      .data_bus    (data_bus),
      .w           (w),
      .r           (r),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_color   (pix_color)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Reference model: command queue, cursor, color and sticky flags.
   pix_cmd_t   q[$];
   int         mx = 0;
   int         my = 0;
   logic [7:0] mc = 8'd0;
   bit         m_ov = 1'b0, m_clip = 1'b0, m_wprev = 1'b0, m_rprev = 1'b0;
   logic [7:0] m_addr = 8'd0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         mx <= 0; my <= 0; mc <= 8'd0;
         m_ov <= 1'b0; m_clip <= 1'b0; m_wprev <= 1'b0; m_rprev <= 1'b0;
         m_addr <= 8'd0;
      end else begin : mstep
         automatic bit was_full = (q.size() == 8);
         automatic bit do_pop   = (q.size() > 0) && pix_ready;
         automatic bit do_push  = 1'b0;
         automatic bit set_ov   = 1'b0;
         automatic bit set_clip = 1'b0;
         automatic bit clr      = m_rprev && !r && (m_addr == 8'd6);
         automatic int nx = mx;
         automatic int ny = my;
         if (w && !m_wprev) begin
            case (address_bus)
               8'd0: nx = (mx / 256) * 256 + int'(data_bus);
               8'd1: nx = (mx % 256) + 256 * int'(data_bus % 8'd4);
               8'd2: ny = (my / 256) * 256 + int'(data_bus);
               8'd3: ny = (my % 256) + 256 * int'(data_bus % 8'd2);
               8'd4: mc <= data_bus;
               8'd5: begin
                  if (data_bus[0]) begin
                     if (mx >= 640 || my >= 480) set_clip = 1'b1;
                     else if (was_full)          set_ov = 1'b1;
                     else                        do_push = 1'b1;
                  end
                  if (data_bus[1]) begin
                     nx = mx + 1;
                     if (nx >= 640) begin
                        nx = 0;
                        ny = my + 1;
                        if (ny >= 480) ny = 0;
                     end
                  end
               end
               default: ;
            endcase
         end
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back('{x: 10'(mx), y: 9'(my), color: mc});
         mx <= nx;
         my <= ny;
         if (set_ov) m_ov <= 1'b1; else if (clr) m_ov <= 1'b0;
         if (set_clip) m_clip <= 1'b1; else if (clr) m_clip <= 1'b0;
         m_wprev <= w;
         m_rprev <= r;
         m_addr  <= address_bus;
      end
   end

   function automatic logic [7:0] model_status();
      int n = q.size();
      return {m_clip, m_ov, 4'(n > 15 ? 15 : n), (n == 0), (n == 8)};
   endfunction

   // Per-cycle comparison of the pixel port against the model head.
   always @(negedge clk) begin
      if (reset) begin
         check("pix_valid", pix_valid, q.size() > 0);
         if (q.size() > 0) begin
            check("pix_x", pix_x, q[0].x);
            check("pix_y", pix_y, q[0].y);
            check("pix_color", pix_color, q[0].color);
         end else begin
            check("pix_x_idle", pix_x, 32'd0);
            check("pix_y_idle", pix_y, 32'd0);
            check("pix_color_idle", pix_color, 32'd0);
         end
      end
   end

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      address_bus = a; tb_data = d; tb_drive = 1'b1; w = 1'b1;
      @(negedge clk);
      w = 1'b0; tb_drive = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
      @(negedge clk);
      tb_drive = 1'b0; address_bus = a; r = 1'b1;
      #1;
      check(nm, data_bus, exp);
      if (a == 8'd6) check({nm, "_model"}, data_bus, model_status());
      @(negedge clk);
      r = 1'b0;
   endtask

   task automatic drain(input int exp_pops, input string nm);
      int pops = 0;
      @(negedge clk);
      pix_ready = 1'b1;
      for (int i = 0; i < 20 && pix_valid; i++) begin
         @(negedge clk);
         pops++;
      end
      pix_ready = 1'b0;
      check({nm, "_pops"}, pops, exp_pops);
      check({nm, "_empty"}, pix_valid, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", pix_valid, 32'd0);
      check("rst_x", pix_x, 32'd0);
      reset = 1'b1;
      rd(8'd6, 8'h02, "rst_status");

      // Single plot, fall-through and pop.
      wr(8'd0, 8'd5); wr(8'd1, 8'd0); wr(8'd2, 8'd7); wr(8'd3, 8'd0);
      wr(8'd4, 8'hE0); wr(8'd5, 8'h01);
      check("t1_valid", pix_valid, 32'd1);
      check("t1_x", pix_x, 32'd5);
      check("t1_y", pix_y, 32'd7);
      check("t1_color", pix_color, 32'hE0);
      drain(1, "t1");
      rd(8'd6, 8'h02, "t1_status");

      // Plot with auto-increment across the bottom-right corner.
      wr(8'd0, 8'h7E); wr(8'd1, 8'd2); wr(8'd2, 8'hDF); wr(8'd3, 8'd1);
      repeat (3) wr(8'd5, 8'h03);
      check("t2_head_x", pix_x, 32'd638);
      check("t2_head_y", pix_y, 32'd479);
      rd(8'd6, 8'h0C, "t2_status");
      rd(8'd0, 8'h01, "t2_xlo");
      rd(8'd2, 8'h00, "t2_ylo");
      rd(8'd5, 8'h00, "cmd_reads0");
      rd(8'd4, 8'hE0, "color_rb");
      drain(3, "t2");

      // Clip and read-clear.
      wr(8'd0, 8'h80); wr(8'd1, 8'd2); wr(8'd5, 8'h01);
      check("t3_novalid", pix_valid, 32'd0);
      rd(8'd6, 8'h82, "t3_clip");
      rd(8'd6, 8'h02, "t3_cleared");

      // Overflow with nine plots, then a refused push while popping.
      wr(8'd0, 8'd10); wr(8'd1, 8'd0);
      repeat (9) wr(8'd5, 8'h03);
      rd(8'd6, 8'h61, "t4_full");
      @(negedge clk);
      pix_ready = 1'b1; address_bus = 8'd5; tb_data = 8'h01; tb_drive = 1'b1; w = 1'b1;
      @(negedge clk);
      pix_ready = 1'b0; w = 1'b0; tb_drive = 1'b0;
      check("t5_head_x", pix_x, 32'd11);
      rd(8'd6, 8'h5C, "t5_status");
      drain(7, "t5");

      // Held write strobe yields one entry; async reset flushes the queue.
      @(negedge clk);
      address_bus = 8'd5; tb_data = 8'h01; tb_drive = 1'b1; w = 1'b1;
      repeat (5) @(negedge clk);
      w = 1'b0; tb_drive = 1'b0;
      rd(8'd6, 8'h04, "t6_one");
      repeat (3) wr(8'd5, 8'h01);
      rd(8'd6, 8'h10, "t6_four");
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check("t6_async_valid", pix_valid, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      rd(8'd6, 8'h02, "t6_after_rst");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
